// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the single-port weight block ROM between the
// weight loader (port 0) and the network evaluator (port 1). Whole bursts of
// consecutive addresses are granted, in-flight reads are tracked through the
// ROM read latency, and each returned word is steered to its owner.
// Optional build macro: ROM_ARB_FIXED_PRIO_EN gives port 0 fixed priority
// instead of round-robin.
//
// state | meaning
// IDLE  | no burst active; arbitrate between pending requests
// BURST | issuing one ROM address per cycle for the current owner
module rom_port_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [2:0]        len0,
  input  logic [2:0]        len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0]        MAX_L    = 4'(MAX_BURST);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        beat_q;
  logic [2:0]        last_q;
  logic              owner_q;
  logic              first_q;
  logic              last_gnt_q;
  logic              cand0, cand1, win_any, winner, last_beat;
  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] po_q;

  // Index of the final beat: length 0 acts as 1, oversize lengths clamp.
  function automatic logic [2:0] eff_last(input logic [2:0] len);
    logic [2:0] r;
    if (len == 3'd0)
      r = 3'd0;
    else if ({1'b0, len} > MAX_L)
      r = 3'(MAX_L - 4'd1);
    else
      r = len - 3'd1;
    return r;
  endfunction

  // Arbitration: candidates exist in IDLE or on the last beat; the current
  // owner is excluded on its last beat because its req may still be high.
  always_comb begin
    cand0     = 1'b0;
    cand1     = 1'b0;
    winner    = 1'b0;
    last_beat = (state_q == BURST) && (beat_q == last_q);
    if (state_q == IDLE) begin
      cand0 = req0;
      cand1 = req1;
    end else if (last_beat) begin
      cand0 = req0 && owner_q;
      cand1 = req1 && !owner_q;
    end
    win_any = cand0 | cand1;
`ifdef ROM_ARB_FIXED_PRIO_EN
    winner = !cand0;
`else
    if (cand0 && cand1)
      winner = !last_gnt_q;
    else
      winner = cand1;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state and ROM-side outputs.
  always_comb begin
    state_d  = state_q;
    rom_en   = 1'b0;
    rom_addr = '0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any)
          state_d = BURST;
      end
      BURST: begin
        rom_en   = 1'b1;
        rom_addr = addr_q;
        gnt0     = first_q && !owner_q;
        gnt1     = first_q && owner_q;
        if (last_beat)
          state_d = win_any ? BURST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst datapath: latch the winner's burst, otherwise advance the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      beat_q     <= 3'd0;
      last_q     <= 3'd0;
      owner_q    <= 1'b0;
      first_q    <= 1'b0;
      last_gnt_q <= 1'b1;
    end else if (win_any) begin
      addr_q     <= winner ? addr1 : addr0;
      last_q     <= eff_last(winner ? len1 : len0);
      beat_q     <= 3'd0;
      owner_q    <= winner;
      first_q    <= 1'b1;
      last_gnt_q <= winner;
    end else if (state_q == BURST) begin
      addr_q  <= addr_q + ADDR_ONE;
      beat_q  <= beat_q + 3'd1;
      first_q <= 1'b0;
    end
  end

  // Return path: {valid, owner} delayed by the ROM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
      po_q <= '0;
    end else begin
      pv_q[0] <= rom_en;
      po_q[0] <= owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

  assign rvalid0 = pv_q[RD_LAT-1] && !po_q[RD_LAT-1];
  assign rvalid1 = pv_q[RD_LAT-1] && po_q[RD_LAT-1];
  assign rdata   = rom_data;
  assign busy    = (state_q == BURST) || (|pv_q);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: four arbiter instances with RD_LAT = 1..4 share one
// stimulus; each has its own ROM model with matching latency.
module tb_rom_port_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic        g0;
    logic        g1;
    logic        r0;
    logic        r1;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [4:0] addr0, addr1;
  logic [2:0] len0, len1;

  logic        gnt0_v    [4];
  logic        gnt1_v    [4];
  logic        rvalid0_v [4];
  logic        rvalid1_v [4];
  logic        busy_v    [4];
  logic        rom_en_v  [4];
  logic [4:0]  rom_addr_v[4];
  logic [31:0] rdata_v   [4];
  logic [31:0] rom_data_v[4];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected issue schedule, one entry per ROM address cycle after arbitration.
  int         sp[$];
  logic [4:0] sa[$];
  bit         sf[$];

  function automatic logic [31:0] rom_word(input logic [4:0] a);
    return {8'hC3, 3'b000, a, 8'h5A, 3'b000, ~a};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [4:0] ap [4];

    rom_port_arbiter #(.RD_LAT(g + 1)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0),
      .req1     (req1),
      .addr0    (addr0),
      .addr1    (addr1),
      .len0     (len0),
      .len1     (len1),
      .gnt0     (gnt0_v[g]),
      .gnt1     (gnt1_v[g]),
      .rvalid0  (rvalid0_v[g]),
      .rvalid1  (rvalid1_v[g]),
      .rdata    (rdata_v[g]),
      .busy     (busy_v[g]),
      .rom_en   (rom_en_v[g]),
      .rom_addr (rom_addr_v[g]),
      .rom_data (rom_data_v[g])
    );

    always @(posedge clk) begin
      ap[0] <= rom_addr_v[g];
      for (int j = 1; j < 4; j++) ap[j] <= ap[j-1];
    end
    assign rom_data_v[g] = rom_word(ap[g]);
  end

  task automatic clear_sched();
    sp.delete();
    sa.delete();
    sf.delete();
  endtask

  task automatic push_burst(input int port, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      sp.push_back(port);
      sa.push_back(5'(start + k));
      sf.push_back(k == 0);
    end
  endtask

  // Expected outputs of instance g in cycle i after the arbitration edge.
  function automatic exp_t expect_at(input int i, input int g);
    exp_t e;
    int n, lat, j;
    n   = sp.size();
    lat = g + 1;
    j   = i - lat;
    e   = '0;
    if (i < n) begin
      e.en   = 1'b1;
      e.addr = sa[i];
      e.g0   = sf[i] && (sp[i] == 0);
      e.g1   = sf[i] && (sp[i] == 1);
    end
    if (j >= 0 && j < n) begin
      e.r0   = (sp[j] == 0);
      e.r1   = (sp[j] == 1);
      e.data = rom_word(sa[j]);
    end
    e.busy = (i < n + lat);
    return e;
  endfunction

  // A requester drops req once its grant has been seen.
  task automatic drop_granted(input int i);
    if (i < sp.size() && sf[i]) begin
      if (sp[i] == 0) req0 = 1'b0;
      else            req1 = 1'b0;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      for (int g = 0; g < 4; g++) begin
        n_tests++;
        if ({gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g], rom_en_v[g], busy_v[g]} !== 6'b0) begin
          n_fail++;
          $display("FAIL reset_flags g=%0d pass=%0d got gnt=%b%b rv=%b%b en=%b busy=%b want all 0",
                   g, pass, gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g], rom_en_v[g], busy_v[g]);
        end
        n_tests++;
        if (rom_addr_v[g] !== 5'd0) begin
          n_fail++;
          $display("FAIL reset_addr g=%0d got %0d want 0", g, rom_addr_v[g]);
        end
        n_tests++;
        if (rdata_v[g] !== rom_data_v[g]) begin
          n_fail++;
          $display("FAIL reset_rdata g=%0d got %h want %h", g, rdata_v[g], rom_data_v[g]);
        end
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_single_burst();
    exp_t e;
    clear_sched();
    push_burst(0, 7, 4);
    req0 = 1; addr0 = 5'd7; len0 = 3'd4;
    for (int c = 1; c <= sp.size() + 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        e = expect_at(c - 1, g);
        n_tests++;
        if ({rom_en_v[g], rom_addr_v[g]} !== {e.en, e.addr}) begin
          n_fail++;
          $display("FAIL single_issue g=%0d i=%0d got en=%b addr=%0d want en=%b addr=%0d", g, c-1, rom_en_v[g], rom_addr_v[g], e.en, e.addr);
        end
        n_tests++;
        if ({gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g]} !== {e.g0, e.g1, e.r0, e.r1}) begin
          n_fail++;
          $display("FAIL single_strobes g=%0d i=%0d got gnt=%b%b rv=%b%b want gnt=%b%b rv=%b%b", g, c-1, gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g], e.g0, e.g1, e.r0, e.r1);
        end
        if (e.r0 || e.r1) begin
          n_tests++;
          if (rdata_v[g] !== e.data) begin
            n_fail++;
            $display("FAIL single_rdata g=%0d i=%0d got %h want %h", g, c-1, rdata_v[g], e.data);
          end
        end
        n_tests++;
        if (busy_v[g] !== e.busy) begin
          n_fail++;
          $display("FAIL single_busy g=%0d i=%0d got %b want %b", g, c-1, busy_v[g], e.busy);
        end
      end
      drop_granted(c - 1);
    end
  endtask

  task automatic test_wrap_clamp();
    exp_t e;
    clear_sched();
    push_burst(1, 30, 4);
    req1 = 1; addr1 = 5'd30; len1 = 3'd7;
    for (int c = 1; c <= sp.size() + 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        e = expect_at(c - 1, g);
        n_tests++;
        if ({rom_en_v[g], rom_addr_v[g]} !== {e.en, e.addr}) begin
          n_fail++;
          $display("FAIL wrap_issue g=%0d i=%0d got en=%b addr=%0d want en=%b addr=%0d", g, c-1, rom_en_v[g], rom_addr_v[g], e.en, e.addr);
        end
        n_tests++;
        if ({gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g]} !== {e.g0, e.g1, e.r0, e.r1}) begin
          n_fail++;
          $display("FAIL wrap_strobes g=%0d i=%0d got gnt=%b%b rv=%b%b want gnt=%b%b rv=%b%b", g, c-1, gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g], e.g0, e.g1, e.r0, e.r1);
        end
        if (e.r0 || e.r1) begin
          n_tests++;
          if (rdata_v[g] !== e.data) begin
            n_fail++;
            $display("FAIL wrap_rdata g=%0d i=%0d got %h want %h", g, c-1, rdata_v[g], e.data);
          end
        end
        n_tests++;
        if (busy_v[g] !== e.busy) begin
          n_fail++;
          $display("FAIL wrap_busy g=%0d i=%0d got %b want %b", g, c-1, busy_v[g], e.busy);
        end
      end
      drop_granted(c - 1);
    end
  endtask

  task automatic test_len_zero();
    exp_t e;
    clear_sched();
    push_burst(0, 3, 1);
    req0 = 1; addr0 = 5'd3; len0 = 3'd0;
    for (int c = 1; c <= sp.size() + 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        e = expect_at(c - 1, g);
        n_tests++;
        if ({rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g]} !== {e.en, e.addr, e.g0, e.g1}) begin
          n_fail++;
          $display("FAIL len0_issue g=%0d i=%0d got en=%b addr=%0d gnt=%b%b want en=%b addr=%0d gnt=%b%b", g, c-1, rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g], e.en, e.addr, e.g0, e.g1);
        end
        n_tests++;
        if ({rvalid0_v[g], rvalid1_v[g], busy_v[g]} !== {e.r0, e.r1, e.busy}) begin
          n_fail++;
          $display("FAIL len0_return g=%0d i=%0d got rv=%b%b busy=%b want rv=%b%b busy=%b", g, c-1, rvalid0_v[g], rvalid1_v[g], busy_v[g], e.r0, e.r1, e.busy);
        end
        if (e.r0 || e.r1) begin
          n_tests++;
          if (rdata_v[g] !== e.data) begin
            n_fail++;
            $display("FAIL len0_rdata g=%0d i=%0d got %h want %h", g, c-1, rdata_v[g], e.data);
          end
        end
      end
      drop_granted(c - 1);
    end
  endtask

  // Rounds: both ports (port 0 favoured after reset), port 0 alone, both again.
  task automatic test_contention();
    exp_t e;
    apply_reset();
    for (int round = 0; round < 3; round++) begin
      clear_sched();
      if (round == 0) begin
        push_burst(0, 4, 2);
        push_burst(1, 9, 2);
        req0 = 1; addr0 = 5'd4; len0 = 3'd2;
        req1 = 1; addr1 = 5'd9; len1 = 3'd2;
      end else if (round == 1) begin
        push_burst(0, 24, 1);
        req0 = 1; addr0 = 5'd24; len0 = 3'd1;
      end else begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        push_burst(0, 2, 2);
        push_burst(1, 17, 2);
`else
        push_burst(1, 17, 2);
        push_burst(0, 2, 2);
`endif
        req0 = 1; addr0 = 5'd2;  len0 = 3'd2;
        req1 = 1; addr1 = 5'd17; len1 = 3'd2;
      end
      for (int c = 1; c <= sp.size() + 6; c++) begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
          e = expect_at(c - 1, g);
          n_tests++;
          if ({rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g]} !== {e.en, e.addr, e.g0, e.g1}) begin
            n_fail++;
            $display("FAIL contend_issue r=%0d g=%0d i=%0d got en=%b addr=%0d gnt=%b%b want en=%b addr=%0d gnt=%b%b", round, g, c-1, rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g], e.en, e.addr, e.g0, e.g1);
          end
          n_tests++;
          if ({rvalid0_v[g], rvalid1_v[g], busy_v[g]} !== {e.r0, e.r1, e.busy}) begin
            n_fail++;
            $display("FAIL contend_return r=%0d g=%0d i=%0d got rv=%b%b busy=%b want rv=%b%b busy=%b", round, g, c-1, rvalid0_v[g], rvalid1_v[g], busy_v[g], e.r0, e.r1, e.busy);
          end
          if (e.r0 || e.r1) begin
            n_tests++;
            if (rdata_v[g] !== e.data) begin
              n_fail++;
              $display("FAIL contend_rdata r=%0d g=%0d i=%0d got %h want %h", round, g, c-1, rdata_v[g], e.data);
            end
          end
        end
        drop_granted(c - 1);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    clear_sched();
    push_burst(0, 12, 4);
    req0 = 1; addr0 = 5'd12; len0 = 3'd4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        e = expect_at(c - 1, g);
        n_tests++;
        if ({rom_en_v[g], rom_addr_v[g], rvalid0_v[g]} !== {e.en, e.addr, e.r0}) begin
          n_fail++;
          $display("FAIL midrst_pre g=%0d i=%0d got en=%b addr=%0d rv0=%b want en=%b addr=%0d rv0=%b", g, c-1, rom_en_v[g], rom_addr_v[g], rvalid0_v[g], e.en, e.addr, e.r0);
        end
      end
      drop_granted(c - 1);
    end
    reset = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n_tests++;
      if ({gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g], rom_en_v[g], busy_v[g], rom_addr_v[g]} !== 11'b0) begin
        n_fail++;
        $display("FAIL midrst_now g=%0d got gnt=%b%b rv=%b%b en=%b busy=%b addr=%0d want all 0", g, gnt0_v[g], gnt1_v[g], rvalid0_v[g], rvalid1_v[g], rom_en_v[g], busy_v[g], rom_addr_v[g]);
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        n_tests++;
        if ({rvalid0_v[g], rvalid1_v[g], rom_en_v[g], busy_v[g]} !== 4'b0) begin
          n_fail++;
          $display("FAIL midrst_after g=%0d c=%0d got rv=%b%b en=%b busy=%b want 0", g, c, rvalid0_v[g], rvalid1_v[g], rom_en_v[g], busy_v[g]);
        end
      end
    end
    clear_sched();
    push_burst(0, 20, 2);
    req0 = 1; addr0 = 5'd20; len0 = 3'd2;
    for (int c = 1; c <= sp.size() + 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        e = expect_at(c - 1, g);
        n_tests++;
        if ({rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g]} !== {e.en, e.addr, e.g0, e.g1}) begin
          n_fail++;
          $display("FAIL midrst_fresh_issue g=%0d i=%0d got en=%b addr=%0d gnt=%b%b want en=%b addr=%0d gnt=%b%b", g, c-1, rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g], e.en, e.addr, e.g0, e.g1);
        end
        n_tests++;
        if ({rvalid0_v[g], rvalid1_v[g], busy_v[g]} !== {e.r0, e.r1, e.busy}) begin
          n_fail++;
          $display("FAIL midrst_fresh_return g=%0d i=%0d got rv=%b%b busy=%b want rv=%b%b busy=%b", g, c-1, rvalid0_v[g], rvalid1_v[g], busy_v[g], e.r0, e.r1, e.busy);
        end
      end
      drop_granted(c - 1);
    end
  endtask

  // Mixed-owner back-to-back bursts on all four latencies; also checks that
  // the two rvalid strobes never coincide.
  task automatic test_latency_sweep();
    exp_t e;
    clear_sched();
`ifdef ROM_ARB_FIXED_PRIO_EN
    push_burst(0, 16, 2);
    push_burst(1, 5, 3);
`else
    push_burst(1, 5, 3);
    push_burst(0, 16, 2);
`endif
    req0 = 1; addr0 = 5'd16; len0 = 3'd2;
    req1 = 1; addr1 = 5'd5;  len1 = 3'd3;
    for (int c = 1; c <= sp.size() + 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        e = expect_at(c - 1, g);
        n_tests++;
        if ({rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g]} !== {e.en, e.addr, e.g0, e.g1}) begin
          n_fail++;
          $display("FAIL sweep_issue lat=%0d i=%0d got en=%b addr=%0d gnt=%b%b want en=%b addr=%0d gnt=%b%b", g+1, c-1, rom_en_v[g], rom_addr_v[g], gnt0_v[g], gnt1_v[g], e.en, e.addr, e.g0, e.g1);
        end
        n_tests++;
        if ({rvalid0_v[g], rvalid1_v[g], busy_v[g]} !== {e.r0, e.r1, e.busy}) begin
          n_fail++;
          $display("FAIL sweep_return lat=%0d i=%0d got rv=%b%b busy=%b want rv=%b%b busy=%b", g+1, c-1, rvalid0_v[g], rvalid1_v[g], busy_v[g], e.r0, e.r1, e.busy);
        end
        if (e.r0 || e.r1) begin
          n_tests++;
          if (rdata_v[g] !== e.data) begin
            n_fail++;
            $display("FAIL sweep_rdata lat=%0d i=%0d got %h want %h", g+1, c-1, rdata_v[g], e.data);
          end
        end
        n_tests++;
        if ((rvalid0_v[g] & rvalid1_v[g]) !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_overlap lat=%0d i=%0d got rv=%b%b want not both", g+1, c-1, rvalid0_v[g], rvalid1_v[g]);
        end
      end
      drop_granted(c - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wrap_clamp();
    test_len_zero();
    test_contention();
    test_reset_mid_burst();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
